// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT stage control: stage state encodings and
// the Q8 quarter-wave cosine table used by the twiddle mapping.
package fft_pkg;

   localparam int TW_MAX_N = 64;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_BFLY = 2'd1,
      ST_ROT  = 2'd2
   } tw_state_e;

   // Quarter-wave cosine table, C[k] = round(256 * cos(k*pi/32)), k = 0..16
   function automatic int tw_c(input int idx);
      case (idx)
         0:       return 256;
         1:       return 255;
         2:       return 251;
         3:       return 245;
         4:       return 237;
         5:       return 226;
         6:       return 213;
         7:       return 198;
         8:       return 181;
         9:       return 162;
         10:      return 142;
         11:      return 121;
         12:      return 98;
         13:      return 74;
         14:      return 50;
         15:      return 25;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Combinational quadrant mapping of a 64-point twiddle exponent e (0..31)
// onto the quarter-wave table, with optional conjugation for the inverse FFT.
module twiddle_rom
   import fft_pkg::*;
#(
   parameter int DATA_W = 24
) (
   input  logic [4:0]        e,
   input  logic              inv,
   output logic [DATA_W-1:0] w_r,
   output logic [DATA_W-1:0] w_i
);

   int e_int;
   int re_val;
   int im_val;

   // First half-circle quadrant (e <= 16) reads C directly; the second mirrors it.
   always_comb begin
      e_int  = int'(e);
      re_val = 0;
      im_val = 0;
      if (e_int <= 16) begin
         re_val = tw_c(e_int);
         im_val = -tw_c(16 - e_int);
      end else begin
         re_val = -tw_c(32 - e_int);
         im_val = -tw_c(e_int - 16);
      end
      if (inv) begin
         im_val = -im_val;
      end
   end

   assign w_r = DATA_W'(re_val);
   assign w_i = DATA_W'(im_val);

endmodule

// File: rtl/twiddle_seq_gen.sv
// Per-stage twiddle sequencer for a radix-2 SDF DIF FFT: counts accepted
// samples, drives FILL/BUTTERFLY/ROTATE and the matching registered twiddle.
module twiddle_seq_gen
   import fft_pkg::*;
#(
   parameter int FFT_N  = 32,
   parameter int STAGE  = 2,
   parameter int DATA_W = 24,
   parameter int FRAC_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   input  logic              inverse,
   output logic [1:0]        state,
   output logic [DATA_W-1:0] w_r,
   output logic [DATA_W-1:0] w_i,
   output logic              out_valid,
   output logic              block_start
);

   localparam int HALF    = FFT_N >> (STAGE + 1);
   localparam int PH_W    = $clog2(2 * HALF);
   localparam int FC_W    = $clog2(HALF + 1);
   localparam int E_SCALE = TW_MAX_N / FFT_N;

   generate
      if (FFT_N < 4 || FFT_N > TW_MAX_N || (FFT_N & (FFT_N - 1)) != 0) begin : g_bad_n
         $error("twiddle_seq_gen: FFT_N must be a power of two in 4..64");
      end
      if (STAGE < 0 || STAGE >= $clog2(FFT_N)) begin : g_bad_stage
         $error("twiddle_seq_gen: STAGE must be in 0..log2(FFT_N)-1");
      end
      if (FRAC_W != 8) begin : g_bad_frac
         $error("twiddle_seq_gen: only FRAC_W=8 is supported by the Q8 table");
      end
      if (DATA_W < 10) begin : g_bad_width
         $error("twiddle_seq_gen: DATA_W must hold +/-256 (at least 10 bits)");
      end
   endgenerate

   logic [FC_W-1:0]   fill_cnt;
   logic [PH_W-1:0]   phase;
   logic              primed;
   logic              inv_lat;
   logic              rot_now;
   logic              inv_eff;
   logic [4:0]        e_next;
   logic [DATA_W-1:0] rom_r;
   logic [DATA_W-1:0] rom_i;

   assign rot_now = primed && (int'(phase) >= HALF);

   // The mode is re-sampled at each block boundary, so the sample at phase 0
   // already sees the new value; every other sample uses the latched mode.
   assign inv_eff = (phase == '0) ? inverse : inv_lat;

   // FILL and BUTTERFLY force m = 0, which the table maps to (1.0, 0).
   always_comb begin
      e_next = '0;
      if (rot_now) begin
         e_next = 5'(((int'(phase) - HALF) << STAGE) * E_SCALE);
      end
   end

   twiddle_rom #(
      .DATA_W (DATA_W)
   ) u_rom (
      .e   (e_next),
      .inv (inv_eff),
      .w_r (rom_r),
      .w_i (rom_i)
   );

   // Counters, mode latch and output registers. block_start is a pulse tied to
   // out_valid, so it drops during input gaps while state and twiddle hold.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         fill_cnt    <= '0;
         phase       <= '0;
         primed      <= 1'b0;
         inv_lat     <= inverse;
         state       <= ST_FILL;
         w_r         <= DATA_W'(1 << FRAC_W);
         w_i         <= '0;
         out_valid   <= 1'b0;
         block_start <= 1'b0;
      end else begin
         out_valid   <= in_valid;
         block_start <= 1'b0;
         if (in_valid) begin
            w_r         <= rom_r;
            w_i         <= rom_i;
            block_start <= primed && (phase == '0);
            if (phase == '0) begin
               inv_lat <= inverse;
            end
            if (!primed) begin
               state    <= ST_FILL;
               fill_cnt <= fill_cnt + FC_W'(1);
               if (fill_cnt == FC_W'(HALF - 1)) begin
                  primed <= 1'b1;
               end
            end else begin
               state <= rot_now ? ST_ROT : ST_BFLY;
               phase <= phase + PH_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_twiddle_seq_gen.sv
// Directed bench for twiddle_seq_gen: three configurations (32/2, 64/0, 32/4)
// share one clock and one set of control inputs.
module tb_twiddle_seq_gen;

   localparam int DW = 24;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clear = 1'b0;
   logic in_valid = 1'b0;
   logic inverse = 1'b0;

   logic [1:0]           a_state, b_state, c_state;
   logic signed [DW-1:0] a_wr, a_wi, b_wr, b_wi, c_wr, c_wi;
   logic                 a_ov, a_bs, b_ov, b_bs, c_ov, c_bs;

   int checks = 0;
   int errors = 0;

   // Hand-computed ROTATE twiddles for FFT_N=32, STAGE=2 (e = 0, 8, 16, 24)
   int rot_wr[4] = '{256, 181, 0, -181};
   int rot_wi[4] = '{0, -181, -256, -181};

   always #5 clk = ~clk;

   twiddle_seq_gen #(.FFT_N(32), .STAGE(2), .DATA_W(DW), .FRAC_W(8)) dut_a (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .inverse(inverse),
      .state(a_state), .w_r(a_wr), .w_i(a_wi), .out_valid(a_ov), .block_start(a_bs)
   );

   twiddle_seq_gen #(.FFT_N(64), .STAGE(0), .DATA_W(DW), .FRAC_W(8)) dut_b (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .inverse(inverse),
      .state(b_state), .w_r(b_wr), .w_i(b_wi), .out_valid(b_ov), .block_start(b_bs)
   );

   twiddle_seq_gen #(.FFT_N(32), .STAGE(4), .DATA_W(DW), .FRAC_W(8)) dut_c (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .inverse(inverse),
      .state(c_state), .w_r(c_wr), .w_i(c_wi), .out_valid(c_ov), .block_start(c_bs)
   );

   task automatic check_output(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic inv);
      @(negedge clk);
      reset    = 1'b0;
      clear    = 1'b0;
      in_valid = v;
      inverse  = inv;
      @(posedge clk);
      #1;
   endtask

   task automatic ctrl_cycle(input logic do_reset, input logic do_clear,
                             input logic v, input logic inv);
      @(negedge clk);
      reset    = do_reset;
      clear    = do_clear;
      in_valid = v;
      inverse  = inv;
      @(posedge clk);
      #1;
   endtask

   // Expected outputs of dut_a for the k-th sample after reset/clear.
   task automatic exp_a(input int k, input bit inv, output int st, output int wr,
                        output int wi, output int bs);
      int p;
      st = 0; wr = 256; wi = 0; bs = 0;
      if (k >= 4) begin
         p = (k - 4) % 8;
         if (p < 4) begin
            st = 1;
            bs = (p == 0) ? 1 : 0;
         end else begin
            st = 2;
            wr = rot_wr[p - 4];
            wi = inv ? -rot_wi[p - 4] : rot_wi[p - 4];
         end
      end
   endtask

   task automatic check_a_sample(input string tag, input int k, input bit inv);
      int st, wr, wi, bs;
      exp_a(k, inv, st, wr, wi, bs);
      check_output($sformatf("%s[%0d].state", tag, k), a_state, st);
      check_output($sformatf("%s[%0d].w_r", tag, k), a_wr, wr);
      check_output($sformatf("%s[%0d].w_i", tag, k), a_wi, wi);
      check_output($sformatf("%s[%0d].out_valid", tag, k), a_ov, 1);
      check_output($sformatf("%s[%0d].block_start", tag, k), a_bs, bs);
   endtask

   task automatic check_a_restart(input string tag);
      check_output({tag, ".state"}, a_state, 0);
      check_output({tag, ".w_r"}, a_wr, 256);
      check_output({tag, ".w_i"}, a_wi, 0);
      check_output({tag, ".out_valid"}, a_ov, 0);
      check_output({tag, ".block_start"}, a_bs, 0);
   endtask

   initial begin
      int st, wr, wi, bs;

      // Reset state
      ctrl_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      ctrl_cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check_a_restart("reset");

      // Continuous stream on 32/2, with the HALF=1 instance alongside
      for (int k = 0; k < 12; k++) begin
         apply_stimulus(1'b1, 1'b0);
         check_a_sample("cont", k, 1'b0);
         check_output($sformatf("last[%0d].state", k), c_state,
                      (k == 0) ? 0 : (((k - 1) % 2 == 0) ? 1 : 2));
         check_output($sformatf("last[%0d].w_r", k), c_wr, 256);
         check_output($sformatf("last[%0d].w_i", k), c_wi, 0);
         check_output($sformatf("last[%0d].block_start", k), c_bs,
                      (k >= 1 && (k - 1) % 2 == 0) ? 1 : 0);
      end

      // Gapped stream: outputs hold and out_valid drops between samples
      ctrl_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 12; k++) begin
         apply_stimulus(1'b1, 1'b0);
         check_a_sample("gap", k, 1'b0);
         apply_stimulus(1'b0, 1'b0);
         exp_a(k, 1'b0, st, wr, wi, bs);
         check_output($sformatf("hold[%0d].state", k), a_state, st);
         check_output($sformatf("hold[%0d].w_r", k), a_wr, wr);
         check_output($sformatf("hold[%0d].w_i", k), a_wi, wi);
         check_output($sformatf("hold[%0d].out_valid", k), a_ov, 0);
         check_output($sformatf("hold[%0d].block_start", k), a_bs, 0);
      end

      // Inverse mode latched at the block boundary, dropped mid-block
      ctrl_cycle(1'b0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 20; k++) begin
         apply_stimulus(1'b1, (k < 8) ? 1'b1 : 1'b0);
         check_a_sample("inv", k, (k < 12) ? 1'b1 : 1'b0);
      end

      // 64-point first stage: full 32-entry rotation, spot checks
      ctrl_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 96; k++) begin
         apply_stimulus(1'b1, 1'b0);
         case (k)
            31: check_output("n64[31].state", b_state, 0);
            32: begin
               check_output("n64[32].state", b_state, 1);
               check_output("n64[32].block_start", b_bs, 1);
            end
            63: check_output("n64[63].state", b_state, 1);
            64: begin
               check_output("n64.e0.state", b_state, 2);
               check_output("n64.e0.w_r", b_wr, 256);
               check_output("n64.e0.w_i", b_wi, 0);
            end
            69: begin
               check_output("n64.e5.w_r", b_wr, 226);
               check_output("n64.e5.w_i", b_wi, -121);
            end
            80: begin
               check_output("n64.e16.w_r", b_wr, 0);
               check_output("n64.e16.w_i", b_wi, -256);
            end
            84: begin
               check_output("n64.e20.w_r", b_wr, -98);
               check_output("n64.e20.w_i", b_wi, -237);
            end
            95: begin
               check_output("n64.e31.state", b_state, 2);
               check_output("n64.e31.w_r", b_wr, -255);
               check_output("n64.e31.w_i", b_wi, -25);
            end
            default: ;
         endcase
      end

      // Restart in the middle of ROTATE, first via clear and then via reset
      for (int r = 0; r < 2; r++) begin
         ctrl_cycle(1'b0, 1'b1, 1'b0, 1'b0);
         for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b1, 1'b0);
         end
         check_a_sample("pre", 9, 1'b0);
         ctrl_cycle((r == 1) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
         check_a_restart((r == 0) ? "midclear" : "midreset");
         for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b1, 1'b0);
            check_a_sample((r == 0) ? "postclear" : "postreset", k, 1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
